// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MIPS multiply/divide unit owning the HI/LO register pair
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             rd_hilo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi_data,
    output logic [WIDTH-1:0] lo_data
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 div0_q, div0_d;
    logic                 done_q, done_d;

    logic                 sgn, is_md, op_div;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum, div_sh;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem, quo_s, rem_s;
    logic [2*WIDTH-1:0]   prod_s;

    // x_q holds the multiplicand (mul) or divisor (div); p_q is the product
    // accumulator for mul, and {remainder, dividend/quotient} for div.
    assign sgn     = (op == 3'd1) || (op == 3'd3);
    assign op_div  = (op == 3'd3) || (op == 3'd4);
    assign is_md   = start && (op >= 3'd1) && (op <= 3'd4);
    assign mag_a   = (sgn && opa[WIDTH-1]) ? -opa : opa;
    assign mag_b   = (sgn && opb[WIDTH-1]) ? -opb : opb;
    assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, x_q} : {(WIDTH+1){1'b0}});
    assign div_sh  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign div_ge  = div_sh >= {1'b0, x_q};
    assign div_rem = div_ge ? WIDTH'(div_sh - {1'b0, x_q}) : div_sh[WIDTH-1:0];
    assign prod_s  = neg_q ? -p_q : p_q;
    assign quo_s   = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    assign rem_s   = neg_rem_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];

    assign busy    = state_q != IDLE;
    assign stall   = busy && (rd_hilo || start);
    assign done    = done_q;
    assign hi_data = hi_q;
    assign lo_data = lo_q;

    // Next-state: accept ops in IDLE, one shift step per CALC cycle, sign fix-up and HI/LO write in FIX
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        x_d       = x_q;
        p_d       = p_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_md) begin
                    state_d   = CALC;
                    count_d   = '0;
                    is_div_d  = op_div;
                    x_d       = op_div ? mag_b : mag_a;
                    p_d       = {{WIDTH{1'b0}}, op_div ? mag_a : mag_b};
                    neg_d     = sgn && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    neg_rem_d = sgn && opa[WIDTH-1];
                    div0_d    = opb == '0;
                end else if (start && op == 3'd5) begin
                    hi_d = opa;
                end else if (start && op == 3'd6) begin
                    lo_d = opa;
                end
            end
            CALC: begin
                count_d = count_q + 1'b1;
                p_d     = is_div_q ? {div_rem, p_q[WIDTH-2:0], div_ge} : {mul_sum, p_q[WIDTH-1:1]};
                state_d = (count_q == CW'(WIDTH - 1)) ? FIX : CALC;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                hi_d    = is_div_q ? rem_s : prod_s[2*WIDTH-1:WIDTH];
                lo_d    = is_div_q ? (div0_q ? {WIDTH{1'b1}} : quo_s) : prod_s[WIDTH-1:0];
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight op and clears HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            x_q       <= '0;
            p_q       <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            x_q       <= x_d;
            p_q       <= p_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed checks of muldiv_seq against an arithmetic reference
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst, start, rd_hilo;
    logic [2:0]  op;
    logic [31:0] opa, opb;
    logic        busy, stall, done;
    logic [31:0] hi_data, lo_data;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .rd_hilo(rd_hilo), .busy(busy), .stall(stall), .done(done),
        .hi_data(hi_data), .lo_data(lo_data)
    );

    always #5 clk = ~clk;

    // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l);
        longint sp, q, r;
        logic [63:0] u;
        case (o)
            3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); u = sp; h = u[63:32]; l = u[31:0]; end
            3'd2: begin u = {32'h0, a} * {32'h0, b}; h = u[63:32]; l = u[31:0]; end
            3'd3: begin
                if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
                else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    l = q[31:0]; h = r[31:0];
                end
            end
            3'd4: begin
                if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
                else begin l = a / b; h = a % b; end
            end
            3'd5: h = a;
            3'd6: l = a;
            default: ;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single edge, then scramble operands (they need not be held)
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; opa = a; opb = b;
        tick();
        start = 1'b0; op = 3'd0; opa = $urandom; opb = $urandom;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; op = 3'd5; opa = 32'hDEAD_BEEF; opb = 32'h0; rd_hilo = 1'b1;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (hi_data !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi_data); end
        checks++; if (lo_data !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo_data); end
        rst = 1'b0; start = 1'b0; op = 3'd0; rd_hilo = 1'b0;
        exp_hi = 32'h0; exp_lo = 32'h0;
        tick();
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [8] = '{3'd2, 3'd1, 3'd1, 3'd3, 3'd4, 3'd4, 3'd3, 3'd3};
        logic [31:0] t_a  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                                  32'd100, 32'h1234, 32'hFFFF_FFFB, 32'h8000_0000};
        logic [31:0] t_b  [8] = '{32'd2, 32'd5, 32'h8000_0000, 32'd2, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] t_h  [8] = '{32'h1, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 32'd2, 32'h1234,
                                  32'hFFFF_FFFB, 32'h0};
        logic [31:0] t_l  [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFF1, 32'h0, 32'hFFFF_FFFD, 32'd14,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        int n;
        for (int i = 0; i < 8; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dir%0d_busy: got %b want 1", i, busy); end
            wait_idle(n);
            checks++; if (n != 33) begin errors++; $display("FAIL dir%0d_latency: got %0d want 33", i, n); end
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL dir%0d_done: got %b want 1", i, done); end
            checks++; if (hi_data !== t_h[i]) begin errors++; $display("FAIL dir%0d_hi: got %h want %h", i, hi_data, t_h[i]); end
            checks++; if (lo_data !== t_l[i]) begin errors++; $display("FAIL dir%0d_lo: got %h want %h", i, lo_data, t_l[i]); end
            tick();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, done); end
            exp_hi = t_h[i]; exp_lo = t_l[i];
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b;
        int n;
        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(1, 6));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom_range(0, 15);
                1: b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
            model(o, a, b, exp_hi, exp_lo);
            issue(o, a, b);
            if (o <= 3'd4) begin
                wait_idle(n);
                checks++; if (n != 33) begin errors++; $display("FAIL rnd%0d_latency: got %0d want 33", i, n); end
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL rnd%0d_done: got %b want 1", i, done); end
            end else begin
                checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rnd%0d_mt_flags: got busy=%b done=%b want 0 0", i, busy, done); end
            end
            checks++; if (hi_data !== exp_hi) begin errors++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h want %h", i, o, a, b, hi_data, exp_hi); end
            checks++; if (lo_data !== exp_lo) begin errors++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h want %h", i, o, a, b, lo_data, exp_lo); end
        end
        tick();
    endtask

    task automatic test_hazard();
        logic [31:0] old_hi;
        int n;
        old_hi = exp_hi;
        model(3'd2, 32'd6, 32'd7, exp_hi, exp_lo);
        issue(3'd2, 32'd6, 32'd7);
        repeat (3) tick();
        start = 1'b1; op = 3'd5; opa = 32'hAA; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hz_mthi_stall: got %b want 1", stall); end
        repeat (5) tick();
        checks++; if (hi_data !== old_hi) begin errors++; $display("FAIL hz_hi_held: got %h want %h", hi_data, old_hi); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hz_stall_held: got %b want 1", stall); end
        start = 1'b0; op = 3'd0; rd_hilo = 1'b1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hz_rd_stall: got %b want 1", stall); end
        rd_hilo = 1'b0; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hz_idle_req_stall: got %b want 0", stall); end
        wait_idle(n);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL hz_done: got %b want 1", done); end
        checks++; if (hi_data !== exp_hi || lo_data !== exp_lo) begin errors++; $display("FAIL hz_result: got %h_%h want %h_%h", hi_data, lo_data, exp_hi, exp_lo); end
        rd_hilo = 1'b1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hz_done_rd_stall: got %b want 0", stall); end
        rd_hilo = 1'b0;
        issue(3'd5, 32'hAA, 32'h0);
        exp_hi = 32'hAA;
        checks++; if (hi_data !== 32'hAA) begin errors++; $display("FAIL hz_mthi: got %h want 000000aa", hi_data); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL hz_mthi_flags: got busy=%b done=%b want 0 0", busy, done); end
        issue(3'd6, 32'h55, 32'h0);
        exp_lo = 32'h55;
        checks++; if (lo_data !== 32'h55 || hi_data !== 32'hAA) begin errors++; $display("FAIL hz_mtlo: got %h_%h want 000000aa_00000055", hi_data, lo_data); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        int n;
        model(3'd4, 32'd1000, 32'd33, exp_hi, exp_lo);
        issue(3'd4, 32'd1000, 32'd33);
        wait_idle(n);
        checks++; if (hi_data !== exp_hi || lo_data !== exp_lo) begin errors++; $display("FAIL b2b_first: got %h_%h want %h_%h", hi_data, lo_data, exp_hi, exp_lo); end
        a = $urandom; b = $urandom;
        model(3'd1, a, b, exp_hi, exp_lo);
        issue(3'd1, a, b);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done); end
        wait_idle(n);
        checks++; if (n != 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", n); end
        checks++; if (hi_data !== exp_hi || lo_data !== exp_lo) begin errors++; $display("FAIL b2b_second: got %h_%h want %h_%h", hi_data, lo_data, exp_hi, exp_lo); end
        tick();
    endtask

    task automatic test_mid_reset();
        int n;
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_hi = 32'h0; exp_lo = 32'h0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy: got %b want 0", busy); end
        checks++; if (hi_data !== 32'h0 || lo_data !== 32'h0) begin errors++; $display("FAIL mr_hilo: got %h_%h want 0_0", hi_data, lo_data); end
        repeat (30) tick();
        checks++; if (hi_data !== 32'h0 || lo_data !== 32'h0 || done !== 1'b0) begin errors++; $display("FAIL mr_no_write: got %h_%h done=%b want 0_0 0", hi_data, lo_data, done); end
        issue(3'd2, 32'd3, 32'd4);
        wait_idle(n);
        checks++; if (lo_data !== 32'd12 || hi_data !== 32'h0) begin errors++; $display("FAIL mr_after: got %h_%h want 0_c", hi_data, lo_data); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; opa = 32'h0; opb = 32'h0; rd_hilo = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_hazard();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
